ascon_xor_begin: RTL and testbench

- Sequential absorb/finalize front end that sits in front of the ASCON permutation core, on the input side of each permutation call.
- Holds the 320-bit state register and absorbs 64-bit rate blocks into state[0] over a valid/ready handshake.
- Returns ciphertext or plaintext over a second handshake and launches permutations through a start/done handshake.
- On the last block it applies padding and the finalization key XOR into state[1]/state[2] before the ROUNDS_A permutation. The downstream end-of-permutation XOR stage then forms the tag.

---
 rtl/ascon_pkg.sv | 29 ++
 rtl/ascon_rate_absorb.sv | 31 +++
 rtl/ascon_xor_begin.sv | 169 ++++++++++++++++
 tb/tb_ascon_xor_begin.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and helpers for the ASCON absorb/finalize front end.
package ascon_pkg;

  localparam int unsigned ROUNDS_A_DEFAULT = 12;
  localparam int unsigned ROUNDS_B_DEFAULT = 6;

  // Word 0 is the rate word; words 1 and 2 take the finalization key.
  typedef logic [4:0][63:0] t_state_array;

  typedef enum logic [2:0] {
    StIdle,
    StAbsorb,
    StOutput,
    StPermReq,
    StPermWait,
    StDone
  } t_fsm_state;

  // Mask that covers the top n bytes of a 64-bit word. If n is 8 or more, every byte is covered.
  function automatic logic [63:0] byte_mask(input logic [3:0] n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (int'(n) > i) m[63-8*i -: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/ascon_rate_absorb.sv
// Combinational rate-word absorb: builds the new state[0], the output block and the padding.
module ascon_rate_absorb
  import ascon_pkg::*;
(
  input  logic [63:0] state0,
  input  logic [63:0] data,
  input  logic [3:0]  n,
  input  logic        last,
  input  logic        decrypt,
  output logic [63:0] state0_new,
  output logic [63:0] out
);

  logic [63:0] mask;
  logic [63:0] m;
  logic [63:0] pad;

  // The pad bit sits directly below the last valid byte. Decrypt overwrites the valid bytes with the ciphertext.
  always_comb begin
    mask = byte_mask(n);
    m    = data & mask;
    pad  = last ? (64'h8000_0000_0000_0000 >> {n, 3'b000}) : '0;
    out  = (state0 ^ m) & mask;
    if (decrypt) begin
      state0_new = (m | (state0 & ~mask)) ^ pad;
    end else begin
      state0_new = state0 ^ m ^ pad;
    end
  end

endmodule

// File: rtl/ascon_xor_begin.sv
// ASCON absorb/finalize front end. This block owns the 320-bit state. It absorbs rate blocks,
// returns the output blocks and requests the permutations. The optional ASCON_ZEROIZE_EN macro
// clears the state after finalization. With that macro, i_start outside IDLE aborts the session.
module ascon_xor_begin
  import ascon_pkg::*;
#(
  parameter int unsigned ROUNDS_A = ROUNDS_A_DEFAULT,
  parameter int unsigned ROUNDS_B = ROUNDS_B_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_decrypt,
  input  logic [127:0] i_key,
  input  logic [63:0]  i_data,
  input  logic [3:0]   i_data_bytes,
  input  logic         i_data_last,
  input  logic         i_data_valid,
  output logic         o_data_ready,
  output logic [63:0]  o_out_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic         o_perm_start,
  output logic [3:0]   o_perm_rounds,
  input  t_state_array i_state,
  input  logic         i_perm_done,
  output t_state_array o_state,
  output logic         o_final_valid,
  output logic         o_err
);

  localparam logic [3:0] RoundsA = 4'(ROUNDS_A);
  localparam logic [3:0] RoundsB = 4'(ROUNDS_B);

  t_fsm_state   fsm_q;
  t_state_array state_q;
  logic         mode_q;
  logic         last_q;
  logic [63:0]  out_q;
  logic         out_valid_q;
  logic         perm_start_q;
  logic [3:0]   rounds_q;
  logic         final_q;
  logic         err_q;

  logic         bad_count;
  logic [63:0]  state0_new;
  logic [63:0]  absorb_out;

  ascon_rate_absorb u_rate_absorb (
    .state0     (state_q[0]),
    .data       (i_data),
    .n          (i_data_bytes),
    .last       (i_data_last),
    .decrypt    (mode_q),
    .state0_new (state0_new),
    .out        (absorb_out)
  );

  // A non-last block must be full. A last block must leave room for the pad bit.
  always_comb begin
    bad_count    = i_data_last ? (i_data_bytes > 4'd7) : (i_data_bytes != 4'd8);
    o_data_ready = (fsm_q == StAbsorb) && !(i_data_valid && bad_count);
  end

  // Session FSM. It owns the state register and every registered output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q        <= StIdle;
      state_q      <= '0;
      mode_q       <= 1'b0;
      last_q       <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      perm_start_q <= 1'b0;
      rounds_q     <= '0;
      final_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      perm_start_q <= 1'b0;
      final_q      <= 1'b0;
`ifdef ASCON_ZEROIZE_EN
      if (i_start && (fsm_q != StIdle)) begin
        fsm_q       <= StIdle;
        state_q     <= '0;
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
`endif
      unique case (fsm_q)
        StIdle: begin
          if (i_start) begin
            state_q <= i_state;
            mode_q  <= i_decrypt;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            fsm_q   <= StAbsorb;
          end
        end
        StAbsorb: begin
          if (i_data_valid) begin
            if (bad_count) begin
              err_q <= 1'b1;
            end else begin
              state_q[0] <= state0_new;
              if (i_data_last) begin
                state_q[1] <= state_q[1] ^ i_key[127:64];
                state_q[2] <= state_q[2] ^ i_key[63:0];
              end
              out_q  <= absorb_out;
              last_q <= i_data_last;
              if (i_data_bytes != 4'd0) begin
                out_valid_q <= 1'b1;
                fsm_q       <= StOutput;
              end else begin
                // An empty last block produces no output, so go straight to the permutation request.
                perm_start_q <= 1'b1;
                rounds_q     <= i_data_last ? RoundsA : RoundsB;
                fsm_q        <= StPermReq;
              end
            end
          end
        end
        StOutput: begin
          if (i_out_ready) begin
            out_valid_q  <= 1'b0;
            perm_start_q <= 1'b1;
            rounds_q     <= last_q ? RoundsA : RoundsB;
            fsm_q        <= StPermReq;
          end
        end
        StPermReq: begin
          fsm_q <= StPermWait;
        end
        StPermWait: begin
          if (i_perm_done) begin
            state_q <= i_state;
            if (last_q) begin
              final_q <= 1'b1;
              fsm_q   <= StDone;
            end else begin
              fsm_q <= StAbsorb;
            end
          end
        end
        StDone: begin
          fsm_q <= StIdle;
`ifdef ASCON_ZEROIZE_EN
          state_q <= '0;
          out_q   <= '0;
`endif
        end
        default: fsm_q <= StIdle;
      endcase
`ifdef ASCON_ZEROIZE_EN
      end
`endif
    end
  end

  assign o_out_data    = out_q;
  assign o_out_valid   = out_valid_q;
  assign o_perm_start  = perm_start_q;
  assign o_perm_rounds = rounds_q;
  assign o_state       = state_q;
  assign o_final_valid = final_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_ascon_xor_begin.sv
// Directed self-checking bench for ascon_xor_begin.
module tb_ascon_xor_begin;
  import ascon_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic         i_decrypt;
  logic [127:0] i_key;
  logic [63:0]  i_data;
  logic [3:0]   i_data_bytes;
  logic         i_data_last;
  logic         i_data_valid;
  logic         o_data_ready;
  logic [63:0]  o_out_data;
  logic         o_out_valid;
  logic         i_out_ready;
  logic         o_perm_start;
  logic [3:0]   o_perm_rounds;
  t_state_array i_state;
  logic         i_perm_done;
  t_state_array o_state;
  logic         o_final_valid;
  logic         o_err;

  int checks = 0;
  int failures = 0;
  int final_cnt = 0;

  ascon_xor_begin dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_decrypt     (i_decrypt),
    .i_key         (i_key),
    .i_data        (i_data),
    .i_data_bytes  (i_data_bytes),
    .i_data_last   (i_data_last),
    .i_data_valid  (i_data_valid),
    .o_data_ready  (o_data_ready),
    .o_out_data    (o_out_data),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_perm_start  (o_perm_start),
    .o_perm_rounds (o_perm_rounds),
    .i_state       (i_state),
    .i_perm_done   (i_perm_done),
    .o_state       (o_state),
    .o_final_valid (o_final_valid),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_final_valid) final_cnt <= final_cnt + 1;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input t_state_array s, input logic dec);
    i_state   = s;
    i_decrypt = dec;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
  endtask

  task automatic put(input logic [63:0] d, input logic [3:0] n, input logic last);
    i_data       = d;
    i_data_bytes = n;
    i_data_last  = last;
    i_data_valid = 1'b1;
    #1;
    chk("data_ready", {63'd0, o_data_ready}, 64'd1);
    tick();
    i_data_valid = 1'b0;
  endtask

  task automatic drain();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
  endtask

  task automatic perm(input t_state_array s);
    i_state     = s;
    i_perm_done = 1'b1;
    tick();
    i_perm_done = 1'b0;
  endtask

  // One-block session that ends in finalization. Checks the output, the key XOR and the final pulse.
  task automatic run_last(input string tag, input t_state_array init, input logic dec,
                          input logic [63:0] d, input logic [3:0] n,
                          input logic [63:0] exp_out, input logic [63:0] exp_s0);
    t_state_array p;
    for (int w = 0; w < 5; w++) p[w] = 64'hC0DE_0000_0000_0000 | 64'(w + 1);
    start(init, dec);
    put(d, n, 1'b1);
    chk({tag, "_s0"}, o_state[0], exp_s0);
    chk({tag, "_s1"}, o_state[1], init[1] ^ i_key[127:64]);
    chk({tag, "_s2"}, o_state[2], init[2] ^ i_key[63:0]);
    if (n != 4'd0) begin
      chk({tag, "_out_valid"}, {63'd0, o_out_valid}, 64'd1);
      chk({tag, "_out_data"}, o_out_data, exp_out);
      chk({tag, "_no_early_start"}, {63'd0, o_perm_start}, 64'd0);
      drain();
    end else begin
      chk({tag, "_no_out_valid"}, {63'd0, o_out_valid}, 64'd0);
    end
    chk({tag, "_perm_start"}, {63'd0, o_perm_start}, 64'd1);
    chk({tag, "_rounds"}, {60'd0, o_perm_rounds}, 64'd12);
    tick();
    chk({tag, "_start_pulse"}, {63'd0, o_perm_start}, 64'd0);
    perm(p);
    chk({tag, "_final"}, {63'd0, o_final_valid}, 64'd1);
    chk({tag, "_permuted"}, o_state[3], p[3]);
    tick();
    chk({tag, "_final_pulse"}, {63'd0, o_final_valid}, 64'd0);
`ifdef ASCON_ZEROIZE_EN
    chk({tag, "_zeroized"}, o_state[0], 64'd0);
`else
    chk({tag, "_retained"}, o_state[0], p[0]);
`endif
  endtask

  initial begin
    t_state_array zero_s;
    t_state_array a5_s;
    t_state_array q;
    logic [63:0] held;
    int fin0;

    zero_s       = '0;
    a5_s         = '0;
    a5_s[0]      = 64'hA5A5_A5A5_A5A5_A5A5;
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_decrypt    = 1'b0;
    i_key        = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    i_data       = '0;
    i_data_bytes = '0;
    i_data_last  = 1'b0;
    i_data_valid = 1'b0;
    i_out_ready  = 1'b0;
    i_state      = '0;
    i_perm_done  = 1'b0;

    // Reset values.
    #2;
    chk("rst_state0", o_state[0], 64'd0);
    chk("rst_ready", {63'd0, o_data_ready}, 64'd0);
    chk("rst_out", o_out_data, 64'd0);
    chk("rst_err", {63'd0, o_err}, 64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Encrypt one last block with n = 3, then the same session with a nonzero rate word.
    run_last("enc", zero_s, 1'b0, 64'h1122_3344_5566_7788, 4'd3,
             64'h1122_3300_0000_0000, 64'h1122_3380_0000_0000);
    run_last("enc_a5", a5_s, 1'b0, 64'h1122_3344_5566_7788, 4'd3,
             64'hB487_9600_0000_0000, 64'hB487_9625_A5A5_A5A5);
    // Decrypt round trips. The low bytes of the ciphertext are garbage and must be masked off.
    run_last("dec", zero_s, 1'b1, 64'h1122_3300_0000_0000, 4'd3,
             64'h1122_3300_0000_0000, 64'h1122_3380_0000_0000);
    run_last("dec_a5", a5_s, 1'b1, 64'hB487_9612_3456_78FF, 4'd3,
             64'h1122_3300_0000_0000, 64'hB487_9625_A5A5_A5A5);
    // An empty last block only toggles the top bit.
    run_last("empty", zero_s, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0,
             64'd0, 64'h8000_0000_0000_0000);

    // Multi-block session: full, full, then last with n = 5.
    fin0 = final_cnt;
    start(zero_s, 1'b0);
    put(64'h0123_4567_89AB_CDEF, 4'd8, 1'b0);
    chk("mb1_out", o_out_data, 64'h0123_4567_89AB_CDEF);
    drain();
    chk("mb1_rounds", {60'd0, o_perm_rounds}, 64'd6);
    tick();
    q = '0;
    q[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    perm(q);
    chk("mb1_ready", {63'd0, o_data_ready}, 64'd1);
    chk("mb1_no_final", {63'd0, o_final_valid}, 64'd0);
    put(64'h0F0F_0F0F_0F0F_0F0F, 4'd8, 1'b0);
    chk("mb2_out", o_out_data, 64'hF0F0_F0F0_F0F0_F0F0);
    drain();
    chk("mb2_rounds", {60'd0, o_perm_rounds}, 64'd6);
    tick();
    perm(zero_s);
    put(64'hAABB_CCDD_EEFF_1122, 4'd5, 1'b1);
    chk("mb3_out", o_out_data, 64'hAABB_CCDD_EE00_0000);
    chk("mb3_s0", o_state[0], 64'hAABB_CCDD_EE80_0000);
    drain();
    chk("mb3_rounds", {60'd0, o_perm_rounds}, 64'd12);
    tick();
    perm(zero_s);
    tick();
    tick();
    chk("mb_final_count", 64'(final_cnt - fin0), 64'd1);

    // Protocol error: a non-last block with n = 4 is refused.
    start(zero_s, 1'b0);
    i_data       = 64'h5555_5555_5555_5555;
    i_data_bytes = 4'd4;
    i_data_last  = 1'b0;
    i_data_valid = 1'b1;
    #1;
    chk("err_ready_low", {63'd0, o_data_ready}, 64'd0);
    tick();
    i_data_valid = 1'b0;
    chk("err_set", {63'd0, o_err}, 64'd1);
    chk("err_no_out", {63'd0, o_out_valid}, 64'd0);
    chk("err_state0", o_state[0], 64'd0);

    // Backpressure: the output is held for 10 cycles and no permutation is requested.
    put(64'h0123_4567_89AB_CDEF, 4'd8, 1'b0);
    held = o_out_data;
    chk("bp_out", held, 64'h0123_4567_89AB_CDEF);
    for (int k = 0; k < 10; k++) begin
`ifndef ASCON_ZEROIZE_EN
      i_start = (k == 3);
      i_state = '1;
`endif
      tick();
      chk("bp_stable", o_out_data, 64'h0123_4567_89AB_CDEF);
      chk("bp_no_start", {63'd0, o_perm_start}, 64'd0);
    end
    i_start = 1'b0;
    chk("bp_start_ignored", o_state[1], 64'd0);
    chk("bp_err_sticky", {63'd0, o_err}, 64'd1);
    drain();
    chk("bp_perm_start", {63'd0, o_perm_start}, 64'd1);
    tick();

    // Reset while in PERM_WAIT abandons the session.
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_state0", o_state[0], 64'd0);
    chk("mid_rst_err", {63'd0, o_err}, 64'd0);
    chk("mid_rst_start", {63'd0, o_perm_start}, 64'd0);
    chk("mid_rst_rounds", {60'd0, o_perm_rounds}, 64'd0);
    chk("mid_rst_out", o_out_data, 64'd0);
    tick();
    i_rst_n = 1'b1;
    q = '1;
    perm(q);
    chk("late_done_state", o_state[0], 64'd0);
    chk("late_done_final", {63'd0, o_final_valid}, 64'd0);
    tick();
    chk("late_done_start", {63'd0, o_perm_start}, 64'd0);
    chk("late_done_ready", {63'd0, o_data_ready}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
